// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential unsigned divider.
// State encoding and counter sizing used by divider_unsigned_seq.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Counter must hold values 0..nb_bits.
    function automatic int cnt_width(input int nb_bits);
        return $clog2(nb_bits + 1);
    endfunction

endpackage

// File: rtl/comparator_unsigned.sv
// Ripple unsigned magnitude comparator: the chain runs LSB to MSB, so the
// most significant differing bit decides the result.
module comparator_unsigned #(
    parameter int nb_bits = 8
) (
    input  logic [nb_bits-1:0] a_i,
    input  logic [nb_bits-1:0] b_i,
    output logic               greater_o,
    output logic               equal_o
);

    logic [nb_bits:0] gt_chain;
    logic [nb_bits:0] eq_chain;

    assign gt_chain[0] = 1'b0;
    assign eq_chain[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < nb_bits; gi++) begin : g_bit
            assign gt_chain[gi+1] = (a_i[gi] & ~b_i[gi])
                                  | (~(a_i[gi] ^ b_i[gi]) & gt_chain[gi]);
            assign eq_chain[gi+1] = eq_chain[gi] & ~(a_i[gi] ^ b_i[gi]);
        end
    endgenerate

    assign greater_o = gt_chain[nb_bits];
    assign equal_o   = eq_chain[nb_bits];

endmodule

// File: rtl/divider_unsigned_seq.sv
// Iterative restoring unsigned divider (DIVU/REMU), one quotient bit per cycle,
// with a start/busy/done handshake and RISC-V divide-by-zero results.
module divider_unsigned_seq
    import div_pkg::*;
#(
    parameter int nb_bits = 32
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [nb_bits-1:0] dividend_i,
    input  logic [nb_bits-1:0] divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [nb_bits-1:0] quotient_o,
    output logic [nb_bits-1:0] remainder_o,
    output logic               div_by_zero_o
);

    localparam int CW = cnt_width(nb_bits);
    localparam logic [CW-1:0] LAST_CNT = CW'(nb_bits - 1);

    div_state_t         state_q, state_d;
    logic [nb_bits-1:0] quo_work_q, quo_work_d;
    logic [nb_bits-1:0] div_q, div_d;
    logic [nb_bits:0]   rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [nb_bits-1:0] quotient_q, quotient_d;
    logic [nb_bits-1:0] remainder_q, remainder_d;
    logic               dbz_q, dbz_d;

    logic [nb_bits:0]   trial;
    logic [nb_bits:0]   divisor_ext;
    logic [nb_bits:0]   diff;
    logic               cmp_gt, cmp_eq, take;
    logic [nb_bits-1:0] step_quo;
    logic [nb_bits:0]   step_rem;
    logic               rem_top_unused;

    assign trial       = {rem_q[nb_bits-1:0], quo_work_q[nb_bits-1]};
    assign divisor_ext = {1'b0, div_q};
    assign diff        = trial - divisor_ext;

    comparator_unsigned #(
        .nb_bits(nb_bits + 1)
    ) u_cmp (
        .a_i      (trial),
        .b_i      (divisor_ext),
        .greater_o(cmp_gt),
        .equal_o  (cmp_eq)
    );

    assign take     = cmp_gt | cmp_eq;
    assign step_quo = {quo_work_q[nb_bits-2:0], take};
    assign step_rem = take ? diff : trial;

    // The remainder never exceeds the divisor, so its top bit stays zero.
    assign rem_top_unused = rem_q[nb_bits];

    always_comb begin
        state_d     = state_q;
        quo_work_d  = quo_work_q;
        div_d       = div_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    quo_work_d = dividend_i;
                    div_d      = divisor_i;
                    rem_d      = '0;
                    cnt_d      = '0;
                    if (divisor_i != '0) begin
                        state_d = RUN;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend_i;
                        dbz_d       = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                quo_work_d = step_quo;
                rem_d      = step_rem;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d     = DONE;
                    quotient_d  = step_quo;
                    remainder_d = step_rem[nb_bits-1:0];
                    dbz_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            quo_work_q  <= '0;
            div_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            quo_work_q  <= quo_work_d;
            div_q       <= div_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy_o        = (state_q == RUN);
    assign done_o        = (state_q == DONE);
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_unsigned_seq.sv
// Self-checking bench: directed 8-bit scenarios plus a 32-bit random sweep,
// checked against plain '/' and '%' with the RISC-V divide-by-zero rule.
module tb_divider_unsigned_seq;

    logic clk;
    logic rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, z8;
    logic [7:0] q8, r8;

    logic        start32;
    logic [31:0] a32, b32;
    logic        busy32, done32, z32;
    logic [31:0] q32, r32;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    divider_unsigned_seq #(.nb_bits(8)) dut8 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start8),
        .dividend_i   (a8),
        .divisor_i    (b8),
        .busy_o       (busy8),
        .done_o       (done8),
        .quotient_o   (q8),
        .remainder_o  (r8),
        .div_by_zero_o(z8)
    );

    divider_unsigned_seq #(.nb_bits(32)) dut32 (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start32),
        .dividend_i   (a32),
        .divisor_i    (b32),
        .busy_o       (busy32),
        .done_o       (done32),
        .quotient_o   (q32),
        .remainder_o  (r32),
        .div_by_zero_o(z32)
    );

    // Issue one 8-bit division (called #1 after an edge) and wait for done.
    // lat = edges after the start edge until done is visible (-1 on timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] q, output logic [7:0] r, output logic z,
                        output int lat, output int busy_cnt, output bit stable);
        logic [7:0] pq, pr;
        logic       pz;
        pq = q8; pr = r8; pz = z8;
        stable = 1'b1; busy_cnt = 0; lat = 0;
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        while (!done8 && lat < 40) begin
            if (busy8) busy_cnt++;
            if (q8 !== pq || r8 !== pr || z8 !== pz) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!done8) lat = -1;
        q = q8; r = r8; z = z8;
        $display("div8  %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d",
                 a, b, q, r, z, lat, busy_cnt);
    endtask

    task automatic run32(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z,
                         output int lat, output int busy_cnt, output bit stable);
        logic [31:0] pq, pr;
        logic        pz;
        pq = q32; pr = r32; pz = z32;
        stable = 1'b1; busy_cnt = 0; lat = 0;
        start32 = 1'b1; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        while (!done32 && lat < 80) begin
            if (busy32) busy_cnt++;
            if (q32 !== pq || r32 !== pr || z32 !== pz) stable = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!done32) lat = -1;
        q = q32; r = r32; z = z32;
        $display("div32 %h / %h -> q=%h r=%h dbz=%0d lat=%0d", a, b, q, r, z, lat);
    endtask

    task automatic test_reset();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
        checks++; if (q8 !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", q8); end
        checks++; if (r8 !== 8'd0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", r8); end
        checks++; if (z8 !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", z8); end
        checks++; if ({busy32, done32, z32} !== 3'b000 || q32 !== 32'd0 || r32 !== 32'd0) begin
            errors++; $display("FAIL reset_dut32: busy=%b done=%b q=%h r=%h dbz=%b expected all 0",
                               busy32, done32, q32, r32, z32);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q, r; logic z; int lat, bc; bit st;
        run8(8'd100, 8'd7, q, r, z, lat, bc, st);
        checks++; if (q !== 8'd14) begin errors++; $display("FAIL basic_quotient: got %0d expected 14", q); end
        checks++; if (r !== 8'd2) begin errors++; $display("FAIL basic_remainder: got %0d expected 2", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz: got %b expected 0", z); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected 8", lat); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 8", bc); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b expected 0", done8); end
        checks++; if (q8 !== 8'd14) begin errors++; $display("FAIL basic_hold_idle: got %0d expected 14", q8); end
    endtask

    task automatic test_div_by_zero();
        logic [7:0] q, r; logic z; int lat, bc; bit st;
        run8(8'd55, 8'd0, q, r, z, lat, bc, st);
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL dbz_quotient: got %h expected ff", q); end
        checks++; if (r !== 8'd55) begin errors++; $display("FAIL dbz_remainder: got %0d expected 55", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", z); end
        checks++; if (lat !== 0) begin errors++; $display("FAIL dbz_latency: got %0d expected 0", lat); end
        checks++; if (bc !== 0) begin errors++; $display("FAIL dbz_busy_cycles: got %0d expected 0", bc); end
        @(posedge clk); #1;
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL dbz_done_pulse: got %b expected 0", done8); end
    endtask

    task automatic test_boundaries();
        logic [7:0] av [4] = '{8'd3, 8'd255, 8'd255, 8'd0};
        logic [7:0] bv [4] = '{8'd200, 8'd1, 8'd255, 8'd9};
        logic [7:0] q, r; logic z; int lat, bc; bit st;
        for (int i = 0; i < 4; i++) begin
            run8(av[i], bv[i], q, r, z, lat, bc, st);
            checks++; if (q !== av[i] / bv[i] || r !== av[i] % bv[i] || z !== 1'b0) begin
                errors++; $display("FAIL boundary_%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=0",
                                   i, q, r, z, av[i] / bv[i], av[i] % bv[i]);
            end
            checks++; if (lat !== 8) begin errors++; $display("FAIL boundary_%0d_latency: got %0d expected 8", i, lat); end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        while (!done8 && lat < 40) begin
            if (lat == 2) begin
                start8 = 1'b1; a8 = 8'd50; b8 = 8'd5;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        if (!done8) lat = -1;
        $display("div8  100 / 7 with mid-run start 50/5 -> q=%0d r=%0d lat=%0d", q8, r8, lat);
        checks++; if (q8 !== 8'd14 || r8 !== 8'd2) begin
            errors++; $display("FAIL ignore_start_result: got q=%0d r=%0d expected q=14 r=2", q8, r8);
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ignore_start_latency: got %0d expected 8", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q, r; logic z; int lat, bc; bit st;
        run8(8'd100, 8'd7, q, r, z, lat, bc, st);
        checks++; if (q !== 8'd14 || r !== 8'd2) begin
            errors++; $display("FAIL b2b_first: got q=%0d r=%0d expected q=14 r=2", q, r);
        end
        run8(8'd50, 8'd5, q, r, z, lat, bc, st);
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL b2b_hold_during_run: got %b expected 1", st); end
        checks++; if (q !== 8'd10 || r !== 8'd0) begin
            errors++; $display("FAIL b2b_second: got q=%0d r=%0d expected q=10 r=0", q, r);
        end
        checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency: got %0d expected 8", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        logic [7:0] q, r; logic z; int lat, bc; bit st;
        int seen_done = 0;
        start8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        $display("div8  reset during 100 / 7 -> busy=%b done=%b q=%0d r=%0d dbz=%b", busy8, done8, q8, r8, z8);
        checks++; if ({busy8, done8, z8} !== 3'b000 || q8 !== 8'd0 || r8 !== 8'd0) begin
            errors++; $display("FAIL abort_outputs: busy=%b done=%b q=%0d r=%0d dbz=%b expected all 0",
                               busy8, done8, q8, r8, z8);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (12) begin
            if (done8 || busy8) seen_done++;
            @(posedge clk); #1;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles expected 0", seen_done); end
        run8(8'd20, 8'd3, q, r, z, lat, bc, st);
        checks++; if (q !== 8'd6 || r !== 8'd2 || z !== 1'b0) begin
            errors++; $display("FAIL abort_next_op: got q=%0d r=%0d dbz=%b expected q=6 r=2 dbz=0", q, r, z);
        end
    endtask

    task automatic test_random_sweep32();
        logic [31:0] a, b, q, r, eq, er;
        logic z;
        int lat, bc, sel;
        bit st;
        for (int i = 0; i < 1002; i++) begin
            a = $urandom;
            sel = $urandom_range(0, 7);
            if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'd2; end
            else if (i == 1) b = 32'd0;
            else if (sel == 0) b = 32'd0;
            else if (sel <= 2) b = 32'($urandom_range(1, 255));
            else if (sel == 3) b = a >> $urandom_range(0, 31);
            else b = $urandom;
            eq = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            er = (b == 32'd0) ? a : a % b;
            run32(a, b, q, r, z, lat, bc, st);
            checks++; if (q !== eq || r !== er || z !== (b == 32'd0)) begin
                errors++; $display("FAIL sweep_result_%0d: got q=%h r=%h dbz=%b expected q=%h r=%h dbz=%b",
                                   i, q, r, z, eq, er, (b == 32'd0));
            end
            checks++; if (lat !== ((b == 32'd0) ? 0 : 32) || bc !== ((b == 32'd0) ? 0 : 32)) begin
                errors++; $display("FAIL sweep_latency_%0d: got lat=%0d busy=%0d expected %0d",
                                   i, lat, bc, (b == 32'd0) ? 0 : 32);
            end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL sweep_hold_%0d: got %b expected 1", i, st); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0;
        #12;
        test_reset();
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic();
        test_div_by_zero();
        test_boundaries();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random_sweep32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
